bank_reader: RTL and testbench

BANK_READER -- requirements
Module: bank_reader

---
 rtl/bank_reader.sv | 114 +++++++++++
 tb/tb_bank_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_reader.sv
// rtl/bank_reader.sv - burst reader: sequential bank reads into a 4-deep FIFO feeding a valid/ready stream
// Optional BANK_READER_TIMEOUT_EN adds a grant-starvation counter with a sticky stall output.
`timescale 1ns/1ps
module bank_reader #(
  parameter int a = 9,
  parameter int w = 128
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [a-1:0] base,
  input  logic [a:0]   len,
  output logic         csel,
  output logic [a-1:0] addr,
  input  logic         grnt,
  input  logic [w-1:0] bdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out_data,
  output logic         busy,
`ifdef BANK_READER_TIMEOUT_EN
  output logic         done,
  output logic         stall
`else
  output logic         done
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t       state, state_next;
  logic [a:0]   remaining;
  logic         inflight;
  logic [2:0]   fifo_count;
  logic [1:0]   head, tail;
  logic [w-1:0] mem [4];
  logic         accept, granted, push, pop;

  // Requests are throttled so a granted word always has a free FIFO slot when it lands.
  always_comb begin
    state_next = state;
    accept     = (state == IDLE) && start;
    csel       = (state == REQ) && (remaining != '0) &&
                 ((fifo_count + 3'(inflight)) < 3'd3);
    granted    = csel && grnt;
    push       = inflight;
    out_valid  = (fifo_count != 3'd0);
    pop        = out_valid && out_ready;
    out_data   = mem[head];
    busy       = (state != IDLE);
    done       = (state == DRAIN) && !inflight && (fifo_count == 3'd0);
    case (state)
      IDLE:  if (accept) state_next = (len != '0) ? REQ : DRAIN;
      REQ:   if ((remaining == '0) || (granted && remaining == (a+1)'(1)))
               state_next = DRAIN;
      DRAIN: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      fifo_count <= 3'd0;
      head       <= 2'd0;
      tail       <= 2'd0;
    end else begin
      state    <= state_next;
      inflight <= granted;
      if (accept) begin
        addr      <= base;
        remaining <= len;
      end else if (granted) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;
    end
  end

  // Storage needs no reset: fifo_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= bdata;
  end

`ifdef BANK_READER_TIMEOUT_EN
  logic [7:0] starve_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 8'd0;
      stall      <= 1'b0;
    end else begin
      if (accept) stall <= 1'b0;
      if (granted) begin
        starve_cnt <= 8'd0;
      end else if (csel) begin
        if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
        if (starve_cnt >= 8'hFE) stall <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bank_reader.sv
// tb/tb_bank_reader.sv - directed vector table plus hand sequences for bank_reader
`timescale 1ns/1ps
module tb_bank_reader;
  localparam int A = 9;
  localparam int W = 128;

  typedef struct {
    logic [A-1:0] base;
    logic [A:0]   len;
    int           rmode;
    int           gmode;
    logic [A-1:0] last;
  } vec_t;

  logic         clk = 1'b0;
  logic         rstn, start, csel, grnt, out_valid, out_ready, busy, done, gnt_en;
  logic [A-1:0] base, addr;
  logic [A:0]   len;
  logic [W-1:0] bdata, out_data;
`ifdef BANK_READER_TIMEOUT_EN
  logic         stall;
`endif

  bank_reader #(.a(A), .w(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
    .csel(csel), .addr(addr), .grnt(grnt), .bdata(bdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
`ifdef BANK_READER_TIMEOUT_EN
    .done(done), .stall(stall)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;
  assign grnt = csel & gnt_en;

  function automatic logic [W-1:0] data_of(input logic [A-1:0] ad);
    return {8{7'b0101010, ad}};
  endfunction

  // Bank model: read data one cycle after a granted access, junk otherwise.
  always @(posedge clk) bdata <= (csel && grnt) ? data_of(addr) : '1;

  int checks = 0, errors = 0;
  logic [A-1:0] gq[$];
  logic [W-1:0] oq[$];
  int gcyc[$], ocyc[$];
  int cyc, dcount, dcyc, nstall, cur_rmode, cur_gmode, s254, s256;
  logic [A-1:0] cur_base;
  bit stall_addr_ok, csel9;
  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rpat(input int m, input int c);
    case (m)
      0: return 1'b1;
      1: return 1'($urandom % 2);
      2: return (c % 3) != 0;
      3: return c >= 10;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic gpat(input int m, input int c);
    case (m)
      1: return 1'($urandom % 2);
      2: return (c % 4) == 0;
      3: return c >= 6;
      4: return c >= 301;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    if (csel && grnt) begin gq.push_back(addr); gcyc.push_back(cyc); end
    if (csel && !grnt) begin
      nstall++;
      if (gq.size() == 0 && addr != cur_base) stall_addr_ok = 1'b0;
`ifdef BANK_READER_TIMEOUT_EN
      if (nstall == 254) s254 = int'(stall);
      if (nstall == 256) s256 = int'(stall);
`endif
    end
    if (out_valid && out_ready) begin oq.push_back(out_data); ocyc.push_back(cyc); end
    if (done) begin dcount++; dcyc = cyc; end
    if (cyc == 9) csel9 = csel;
    @(posedge clk);
    #1;
    cyc++;
    out_ready = rpat(cur_rmode, cyc);
    gnt_en    = gpat(cur_gmode, cyc);
  endtask

  task automatic clear_mon(input logic [A-1:0] b, input int rm, input int gm);
    gq.delete(); oq.delete(); gcyc.delete(); ocyc.delete();
    cyc = 0; dcount = 0; dcyc = -1; nstall = 0; s254 = -1; s256 = -1;
    stall_addr_ok = 1'b1; csel9 = 1'b1;
    cur_base = b; cur_rmode = rm; cur_gmode = gm;
    out_ready = rpat(rm, 0);
    gnt_en    = gpat(gm, 0);
  endtask

  task automatic run_burst(input int k, input vec_t v);
    int bad;
    clear_mon(v.base, v.rmode, v.gmode);
    base = v.base; len = v.len; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3000 && dcount == 0; i++) step();
    repeat (3) step();
    check($sformatf("v%0d grant_count", k), gq.size(), v.len);
    check($sformatf("v%0d word_count", k), oq.size(), v.len);
    bad = -1;
    foreach (gq[i]) if (bad < 0 && gq[i] != A'(v.base + A'(i))) bad = i;
    check($sformatf("v%0d addr_order_first_bad", k), bad, -1);
    if (v.len != 0)
      check($sformatf("v%0d last_addr", k), (gq.size() > 0) ? longint'(gq[gq.size()-1]) : -1, v.last);
    bad = -1;
    foreach (oq[i]) if (bad < 0 && oq[i] != data_of(A'(v.base + A'(i)))) bad = i;
    check($sformatf("v%0d data_order_first_bad", k), bad, -1);
    check($sformatf("v%0d done_pulses", k), dcount, 1);
    check($sformatf("v%0d busy_after", k), busy, 0);
    check($sformatf("v%0d csel_after", k), csel, 0);
    if (v.rmode == 0 && v.gmode == 0 && v.len != 0 && gq.size() == oq.size()) begin
      bad = -1;
      foreach (gcyc[i])
        if (bad < 0 && (gcyc[i] != gcyc[0] + i || ocyc[i] != gcyc[i] + 2)) bad = i;
      check($sformatf("v%0d timing_first_bad", k), bad, -1);
    end
    if (v.len == 0) begin
      check($sformatf("v%0d len0_done_cycle", k), dcyc, 1);
      check($sformatf("v%0d len0_no_csel", k), nstall + gq.size(), 0);
    end
    if (v.rmode == 3) begin
      bad = 0;
      foreach (gcyc[i]) if (gcyc[i] < 10) bad++;
      check($sformatf("v%0d grants_while_blocked", k), bad, 3);
      check($sformatf("v%0d csel_while_blocked", k), csel9, 0);
    end
    if (v.gmode == 3) begin
      check($sformatf("v%0d first_grant_cycle", k), (gcyc.size() > 0) ? gcyc[0] : -1, 6);
      check($sformatf("v%0d stalled_cycles", k), nstall, 5);
      check($sformatf("v%0d addr_held", k), stall_addr_ok, 1);
    end
`ifdef BANK_READER_TIMEOUT_EN
    if (v.gmode == 4) begin
      check($sformatf("v%0d stall_at_254", k), s254, 0);
      check($sformatf("v%0d stall_at_256", k), s256, 1);
      check($sformatf("v%0d stall_sticky", k), stall, 1);
    end
`endif
  endtask

  initial begin
    vecs.push_back('{9'h010,  10'd4,   0, 0, 9'h013});
    vecs.push_back('{9'h1FE,  10'd4,   0, 0, 9'h001});
    vecs.push_back('{9'h000,  10'd1,   1, 1, 9'h000});
    vecs.push_back('{9'h100,  10'd8,   2, 2, 9'h107});
    vecs.push_back('{9'h1FF,  10'd2,   1, 0, 9'h000});
    vecs.push_back('{9'h0AB,  10'd20,  1, 1, 9'h0BE});
    vecs.push_back('{9'h000,  10'd512, 0, 0, 9'h1FF});
    vecs.push_back('{9'h055,  10'd0,   0, 0, 9'h000});
    vecs.push_back('{9'h020,  10'd8,   3, 0, 9'h027});
    vecs.push_back('{9'h0C0,  10'd3,   0, 3, 9'h0C2});
`ifdef BANK_READER_TIMEOUT_EN
    vecs.push_back('{9'h030,  10'd3,   0, 4, 9'h032});
`endif

    rstn = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0; gnt_en = 1'b0;
    #12;
    check("reset csel", csel, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset addr", addr, 0);
    @(posedge clk); #1 rstn = 1'b1;

    foreach (vecs[k]) run_burst(k, vecs[k]);

    // Reset in the middle of a 6-word burst with the stream blocked.
    clear_mon(9'h040, 4, 0);
    base = 9'h040; len = 10'd6; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && gq.size() < 2; i++) step();
    check("midreset grants_before", gq.size(), 2);
    check("midreset csel_before", csel, 1);
    rstn = 1'b0;
    #1;
    check("midreset csel", csel, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset busy", busy, 0);
    #2 rstn = 1'b1;
    clear_mon(9'h040, 0, 0);
    repeat (4) step();
    check("postreset idle_grants", gq.size() + nstall, 0);
    run_burst(99, '{9'h070, 10'd2, 0, 0, 9'h071});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
